// File: rtl/vga_display.sv
// ---------------------------------------------------------------------------
// vga_display
//   Output stage after the image-processing core. Scans the VGA raster, reads
//   the 4-bit processed pixel buffer (mem1) by linear address and drives grey
//   RGB plus hsync/vsync. The screen stays blank until the core reports its
//   first completed frame, after which the raster free-runs until reset.
//
//   The mem1 read has rdLatency clocks of latency (registered address to
//   valid rdata). The visible/sync/frame-start flags are carried through a
//   matching shift register so every output changes on the same clock as the
//   pixel it belongs to. Total counter-to-output latency is rdLatency+2.
//
// Ports
//   clk24        in   pixel clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   core_end     in   one-cycle pulse at the end of each processed frame
//   rdata[3:0]   in   pixel read from mem1
//   addr[18:0]   out  mem1 read address (registered, 0 during blanking)
//   vga_r/g/b    out  4-bit grey level, 0 during blanking
//   vga_hsync    out  horizontal sync, active level = syncPol
//   vga_vsync    out  vertical sync, active level = syncPol
//   frame_start  out  one-cycle pulse with pixel (0,0) at the outputs
// ---------------------------------------------------------------------------
module vga_display #(
  parameter int width     = 640,
  parameter int height    = 480,
  parameter int hFront    = 16,
  parameter int hSync     = 96,
  parameter int hBack     = 48,
  parameter int vFront    = 10,
  parameter int vSync     = 2,
  parameter int vBack     = 33,
  parameter int rdLatency = 1,   // legal range 1..3
  parameter int syncPol   = 0    // 0 = active-low syncs
) (
  input  logic        clk24,
  input  logic        rst_n,
  input  logic        core_end,
  input  logic [3:0]  rdata,
  output logic [18:0] addr,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);

  localparam int HMAX = width + hFront + hSync + hBack;
  localparam int VMAX = height + vFront + vSync + vBack;
  // One spare count of headroom so the sync-end bounds are representable
  // even when a back porch is zero.
  localparam int HW   = $clog2(HMAX + 1);
  localparam int VW   = $clog2(VMAX + 1);
  // Flag delay from counter stage to the output register input.
  localparam int PD   = rdLatency + 1;

  localparam logic SYNC_ACT = (syncPol != 0);

  localparam logic [HW-1:0] H_VIS_END  = HW'(width);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(width + hFront);
  localparam logic [HW-1:0] H_SYNC_END = HW'(width + hFront + hSync);
  localparam logic [HW-1:0] H_LAST     = HW'(HMAX - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(height);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(height + vFront);
  localparam logic [VW-1:0] V_SYNC_END = VW'(height + vFront + vSync);
  localparam logic [VW-1:0] V_LAST     = VW'(VMAX - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          armed_q;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [PD-1:0] vis_pipe_q, hs_pipe_q, vs_pipe_q, fs_pipe_q;

  logic          run;
  logic          vis0, hs0, vs0, fs0;
  logic [18:0]   addr_d;

  // -------------------------------------------------------------------------
  // Raster state machine and counters
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        // armed_q is low on the first clock after reset release, so a
        // core_end coinciding with the release is ignored.
        if (core_end && armed_q) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
    endcase
  end

  assign run  = (state_q == ST_RUN);
  assign vis0 = run && (hcnt_q < H_VIS_END) && (vcnt_q < V_VIS_END);
  assign hs0  = run && (hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END);
  assign vs0  = run && (vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END);
  assign fs0  = run && (hcnt_q == '0) && (vcnt_q == '0);

  assign addr_d = vis0 ? (19'(hcnt_q) + 19'(vcnt_q) * 19'(width)) : 19'd0;

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      addr    <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      addr    <= addr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Flag alignment: one stage for the address register plus rdLatency for
  // the memory, so the flags meet rdata at the output register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      vis_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      fs_pipe_q  <= '0;
    end else begin
      vis_pipe_q <= {vis_pipe_q[PD-2:0], vis0};
      hs_pipe_q  <= {hs_pipe_q[PD-2:0],  hs0};
      vs_pipe_q  <= {vs_pipe_q[PD-2:0],  vs0};
      fs_pipe_q  <= {fs_pipe_q[PD-2:0],  fs0};
    end
  end

  // -------------------------------------------------------------------------
  // Output register. rdata is only passed while the aligned visible flag is
  // set; during blanking it is don't-care and forced to black.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= ~SYNC_ACT;
      vga_vsync   <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= vis_pipe_q[PD-1] ? rdata : 4'h0;
      vga_g       <= vis_pipe_q[PD-1] ? rdata : 4'h0;
      vga_b       <= vis_pipe_q[PD-1] ? rdata : 4'h0;
      vga_hsync   <= hs_pipe_q[PD-1] ? SYNC_ACT : ~SYNC_ACT;
      vga_vsync   <= vs_pipe_q[PD-1] ? SYNC_ACT : ~SYNC_ACT;
      frame_start <= fs_pipe_q[PD-1];
    end
  end

endmodule

// File: tb/tb_vga_display.sv
// ---------------------------------------------------------------------------
// tb_vga_display
//   Directed bench for vga_display using a shrunken raster (8x6 visible,
//   15x11 total) so several frames fit in a short run. Two instances are
//   driven in parallel: rdLatency=1 (D=3) and rdLatency=3 (D=5), each with its
//   own memory model returning (addr % 15) + 1, so blank leakage and
//   misalignment both show as wrong pixel values.
// ---------------------------------------------------------------------------
module tb_vga_display;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HM = W + HF + HS + HB;   // 15
  localparam int VM = H + VF + VS + VB;   // 11
  localparam int FRAME = HM * VM;         // 165

  localparam logic [14:0] BLANK_VEC = {12'h000, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_end = 1'b0;

  logic [3:0]  rdata1, rdata3;
  logic [18:0] addr1, addr3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, fs1, hs3, vs3, fs3;

  logic [3:0]  m1_q  = 4'hF;
  logic [3:0]  m3a_q = 4'hF;
  logic [3:0]  m3b_q = 4'hF;
  logic [3:0]  m3c_q = 4'hF;

  int cyc     = 0;
  int c_start = -1;
  int n_cmp   = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] mem_val(input int a);
    return 4'((a % 15) + 1);
  endfunction

  // Memory models: one register for latency 1, three for latency 3.
  always @(posedge clk) begin
    m1_q  <= mem_val(int'(addr1));
    m3a_q <= mem_val(int'(addr3));
    m3b_q <= m3a_q;
    m3c_q <= m3b_q;
  end
  assign rdata1 = m1_q;
  assign rdata3 = m3c_q;

  vga_display #(
    .width(W), .height(H), .hFront(HF), .hSync(HS), .hBack(HB),
    .vFront(VF), .vSync(VS), .vBack(VB), .rdLatency(1), .syncPol(0)
  ) u_lat1 (
    .clk24(clk), .rst_n(rst_n), .core_end(core_end), .rdata(rdata1),
    .addr(addr1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hsync(hs1), .vga_vsync(vs1), .frame_start(fs1)
  );

  vga_display #(
    .width(W), .height(H), .hFront(HF), .hSync(HS), .hBack(HB),
    .vFront(VF), .vSync(VS), .vBack(VB), .rdLatency(3), .syncPol(0)
  ) u_lat3 (
    .clk24(clk), .rst_n(rst_n), .core_end(core_end), .rdata(rdata3),
    .addr(addr3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .vga_hsync(hs3), .vga_vsync(vs3), .frame_start(fs3)
  );

  // ---------------- reference raster model ----------------
  // Output position for cycle n with latency d (negative = not yet running).
  function automatic int kpos(input int n, input int d);
    if (c_start < 0) return -1;
    return n - c_start - 1 - d;
  endfunction

  function automatic logic [14:0] exp_vec(input int k);
    int h, v;
    logic vis, hs, vs, fs;
    logic [3:0] p;
    if (k < 0) return BLANK_VEC;
    h   = k % HM;
    v   = (k / HM) % VM;
    vis = (h < W) && (v < H);
    p   = vis ? mem_val(h + v * W) : 4'h0;
    hs  = !((h >= W + HF) && (h < W + HF + HS));
    vs  = !((v >= H + VF) && (v < H + VF + VS));
    fs  = (h == 0) && (v == 0);
    return {p, p, p, hs, vs, fs};
  endfunction

  function automatic logic [18:0] exp_addr(input int j);
    int h, v;
    if (j < 0) return 19'd0;
    h = j % HM;
    v = (j / HM) % VM;
    if ((h < W) && (v < H)) return 19'(h + v * W);
    return 19'd0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    core_end = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({r1, g1, b1, hs1, vs1, fs1} !== BLANK_VEC || addr1 !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_lat1 got=%h/%h exp=%h/0", {r1, g1, b1, hs1, vs1, fs1}, addr1, BLANK_VEC);
    end
    n_cmp++;
    if ({r3, g3, b3, hs3, vs3, fs3} !== BLANK_VEC || addr3 !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_lat3 got=%h/%h exp=%h/0", {r3, g3, b3, hs3, vs3, fs3}, addr3, BLANK_VEC);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n = cyc;
      n_cmp++;
      if ({r1, g1, b1, hs1, vs1, fs1, addr1} !== {BLANK_VEC, 19'd0}) begin
        n_bad++;
        $display("FAIL idle_lat1 cyc=%0d got=%h/%h exp=%h/0", n, {r1, g1, b1, hs1, vs1, fs1}, addr1, BLANK_VEC);
      end
      n_cmp++;
      if ({r3, g3, b3, hs3, vs3, fs3, addr3} !== {BLANK_VEC, 19'd0}) begin
        n_bad++;
        $display("FAIL idle_lat3 cyc=%0d got=%h/%h exp=%h/0", n, {r3, g3, b3, hs3, vs3, fs3}, addr3, BLANK_VEC);
      end
    end
    $display("test_reset done at cyc=%0d", cyc);
  endtask

  task automatic test_release_with_core_end();
    int n;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    core_end = 1'b1;
    @(posedge clk); #1 core_end = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n = cyc;
      n_cmp++;
      if ({r1, g1, b1, hs1, vs1, fs1, addr1} !== {BLANK_VEC, 19'd0}) begin
        n_bad++;
        $display("FAIL release_lat1 cyc=%0d got=%h/%h exp=%h/0", n, {r1, g1, b1, hs1, vs1, fs1}, addr1, BLANK_VEC);
      end
      n_cmp++;
      if ({r3, g3, b3, hs3, vs3, fs3, addr3} !== {BLANK_VEC, 19'd0}) begin
        n_bad++;
        $display("FAIL release_lat3 cyc=%0d got=%h/%h exp=%h/0", n, {r3, g3, b3, hs3, vs3, fs3}, addr3, BLANK_VEC);
      end
    end
    $display("test_release_with_core_end done at cyc=%0d", cyc);
  endtask

  task automatic test_first_frame();
    int n;
    @(posedge clk); #1 core_end = 1'b1;
    c_start = cyc;
    @(posedge clk); #1 core_end = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n = cyc;
      n_cmp++;
      if (fs1 !== (n == c_start + 4)) begin
        n_bad++;
        $display("FAIL fs_lat1 cyc=%0d got=%b exp=%b", n - c_start, fs1, (n == c_start + 4));
      end
      n_cmp++;
      if (fs3 !== (n == c_start + 6)) begin
        n_bad++;
        $display("FAIL fs_lat3 cyc=%0d got=%b exp=%b", n - c_start, fs3, (n == c_start + 6));
      end
      if (n == c_start + 4) begin
        n_cmp++;
        if ({r1, g1, b1} !== 12'h111) begin
          n_bad++;
          $display("FAIL pix00_lat1 got=%h exp=111", {r1, g1, b1});
        end
      end
      if (n == c_start + 6) begin
        n_cmp++;
        if ({r3, g3, b3} !== 12'h111) begin
          n_bad++;
          $display("FAIL pix00_lat3 got=%h exp=111", {r3, g3, b3});
        end
      end
    end
    $display("test_first_frame done at cyc=%0d", cyc);
  endtask

  task automatic test_addr();
    int n, j;
    logic [18:0] ea;
    logic [18:0] hand;
    while (cyc < c_start + 170) begin
      @(negedge clk);
      n  = cyc;
      j  = n - c_start - 2;
      ea = exp_addr(j);
      n_cmp++;
      if (addr1 !== ea) begin
        n_bad++;
        $display("FAIL addr_lat1 pos=%0d got=%0d exp=%0d", j, addr1, ea);
      end
      n_cmp++;
      if (addr3 !== ea) begin
        n_bad++;
        $display("FAIL addr_lat3 pos=%0d got=%0d exp=%0d", j, addr3, ea);
      end
      // Hand-derived landmarks: line 1 start/end, first blank, last pixel,
      // wrap to the next frame.
      if (j == 15 || j == 22 || j == 23 || j == 82 || j == 165) begin
        case (j)
          15:      hand = 19'd8;
          22:      hand = 19'd15;
          82:      hand = 19'd47;
          default: hand = 19'd0;
        endcase
        n_cmp++;
        if (addr1 !== hand) begin
          n_bad++;
          $display("FAIL addr_mark pos=%0d got=%0d exp=%0d", j, addr1, hand);
        end
      end
    end
    $display("test_addr done at cyc=%0d", cyc);
  endtask

  task automatic test_sync();
    int n, hrun, vrun, last_fs;
    logic [14:0] e1, e3;
    hrun = 0;
    vrun = 0;
    last_fs = -1;
    for (int i = 0; i < 340; i++) begin
      @(negedge clk);
      n  = cyc;
      e1 = exp_vec(kpos(n, 3));
      e3 = exp_vec(kpos(n, 5));
      n_cmp++;
      if ({r1, g1, b1, hs1, vs1, fs1} !== e1) begin
        n_bad++;
        $display("FAIL sync_lat1 cyc=%0d got=%h exp=%h", n - c_start, {r1, g1, b1, hs1, vs1, fs1}, e1);
      end
      n_cmp++;
      if ({r3, g3, b3, hs3, vs3, fs3} !== e3) begin
        n_bad++;
        $display("FAIL sync_lat3 cyc=%0d got=%h exp=%h", n - c_start, {r3, g3, b3, hs3, vs3, fs3}, e3);
      end
      if (!hs1) hrun++;
      else if (hrun > 0) begin
        n_cmp++;
        if (hrun != HS) begin
          n_bad++;
          $display("FAIL hsync_width got=%0d exp=%0d", hrun, HS);
        end
        hrun = 0;
      end
      if (!vs1) vrun++;
      else if (vrun > 0) begin
        n_cmp++;
        if (vrun != VS * HM) begin
          n_bad++;
          $display("FAIL vsync_width got=%0d exp=%0d", vrun, VS * HM);
        end
        vrun = 0;
      end
      if (fs1 === 1'b1) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (n - last_fs != FRAME) begin
            n_bad++;
            $display("FAIL frame_period got=%0d exp=%0d", n - last_fs, FRAME);
          end
        end
        last_fs = n;
      end
    end
    $display("test_sync done at cyc=%0d", cyc);
  endtask

  task automatic test_data();
    int n, k1, k3;
    logic [14:0] e1, e3;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      n  = cyc;
      k1 = kpos(n, 3);
      k3 = kpos(n, 5);
      e1 = exp_vec(k1);
      e3 = exp_vec(k3);
      n_cmp++;
      if ({r1, g1, b1, hs1, vs1, fs1} !== e1) begin
        n_bad++;
        $display("FAIL data_lat1 cyc=%0d got=%h exp=%h", n - c_start, {r1, g1, b1, hs1, vs1, fs1}, e1);
      end
      n_cmp++;
      if ({r3, g3, b3, hs3, vs3, fs3} !== e3) begin
        n_bad++;
        $display("FAIL data_lat3 cyc=%0d got=%h exp=%h", n - c_start, {r3, g3, b3, hs3, vs3, fs3}, e3);
      end
      // Pixel (1,1) is address 9 -> value 0xA; (8,0) is first blank pixel.
      if (k1 % FRAME == HM + 1) begin
        n_cmp++;
        if ({r1, g1, b1} !== 12'hAAA) begin
          n_bad++;
          $display("FAIL pix11_lat1 got=%h exp=AAA", {r1, g1, b1});
        end
      end
      if (k3 % FRAME == HM + 1) begin
        n_cmp++;
        if ({r3, g3, b3} !== 12'hAAA) begin
          n_bad++;
          $display("FAIL pix11_lat3 got=%h exp=AAA", {r3, g3, b3});
        end
      end
      if (k1 % FRAME == W) begin
        n_cmp++;
        if ({r1, g1, b1} !== 12'h000) begin
          n_bad++;
          $display("FAIL blank80_lat1 got=%h exp=000", {r1, g1, b1});
        end
      end
    end
    $display("test_data done at cyc=%0d", cyc);
  endtask

  task automatic test_mid_reset();
    int n;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (kpos(cyc, 3) % FRAME == 3 * HM + 4) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL midline_wait got=timeout exp=line3");
    end
    @(posedge clk); #3 rst_n = 1'b0;
    c_start = -1;
    #1;
    n_cmp++;
    if ({r1, g1, b1, hs1, vs1, fs1, addr1} !== {BLANK_VEC, 19'd0}) begin
      n_bad++;
      $display("FAIL async_rst_lat1 got=%h/%h exp=%h/0", {r1, g1, b1, hs1, vs1, fs1}, addr1, BLANK_VEC);
    end
    n_cmp++;
    if ({r3, g3, b3, hs3, vs3, fs3, addr3} !== {BLANK_VEC, 19'd0}) begin
      n_bad++;
      $display("FAIL async_rst_lat3 got=%h/%h exp=%h/0", {r3, g3, b3, hs3, vs3, fs3}, addr3, BLANK_VEC);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n = cyc;
      n_cmp++;
      if ({r1, g1, b1, hs1, vs1, fs1, addr1} !== {BLANK_VEC, 19'd0}) begin
        n_bad++;
        $display("FAIL post_rst_lat1 cyc=%0d got=%h/%h exp=%h/0", n, {r1, g1, b1, hs1, vs1, fs1}, addr1, BLANK_VEC);
      end
      n_cmp++;
      if ({r3, g3, b3, hs3, vs3, fs3, addr3} !== {BLANK_VEC, 19'd0}) begin
        n_bad++;
        $display("FAIL post_rst_lat3 cyc=%0d got=%h/%h exp=%h/0", n, {r3, g3, b3, hs3, vs3, fs3}, addr3, BLANK_VEC);
      end
    end
    $display("test_mid_reset done at cyc=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [14:0] e1, e3;
    logic [18:0] ea;
    @(posedge clk); #1 core_end = 1'b1;
    c_start = cyc;
    for (int i = 0; i < 260; i++) begin
      if (i == 0 || i == 61) begin
        @(posedge clk); #1 core_end = 1'b0;
      end else if (i == 60) begin
        @(posedge clk); #1 core_end = 1'b1;   // ignored while running
      end
      @(negedge clk);
      n  = cyc;
      e1 = exp_vec(kpos(n, 3));
      e3 = exp_vec(kpos(n, 5));
      ea = exp_addr(n - c_start - 2);
      n_cmp++;
      if ({r1, g1, b1, hs1, vs1, fs1} !== e1) begin
        n_bad++;
        $display("FAIL b2b_lat1 cyc=%0d got=%h exp=%h", n - c_start, {r1, g1, b1, hs1, vs1, fs1}, e1);
      end
      n_cmp++;
      if ({r3, g3, b3, hs3, vs3, fs3} !== e3) begin
        n_bad++;
        $display("FAIL b2b_lat3 cyc=%0d got=%h exp=%h", n - c_start, {r3, g3, b3, hs3, vs3, fs3}, e3);
      end
      n_cmp++;
      if (addr1 !== ea || addr3 !== ea) begin
        n_bad++;
        $display("FAIL b2b_addr cyc=%0d got=%0d/%0d exp=%0d", n - c_start, addr1, addr3, ea);
      end
      if (n == c_start + 4) begin
        n_cmp++;
        if (fs1 !== 1'b1) begin
          n_bad++;
          $display("FAIL restart_fs got=%b exp=1", fs1);
        end
      end
    end
    $display("test_back_to_back done at cyc=%0d", cyc);
  endtask

  initial begin
    test_reset();
    test_release_with_core_end();
    test_first_frame();
    test_addr();
    test_sync();
    test_data();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
